csa_accum_tree: RTL and testbench



---
 rtl/csa_accum_tree.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_csa_accum_tree.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_tree.sv
// csa_accum_tree
//   Multi-beat carry-save accumulator. Each accepted beat carries ROWS rows of
//   WIDTH bits. A combinational 3:2 compressor tree reduces those rows together
//   with the running carry-save pair (acc0, acc1) down to two words. The result
//   pair (B_0, B_1) is presented through a valid/ready handshake when a beat
//   marked in_last is accepted, or when MAX_BEATS beats have been folded in.
//   All arithmetic is modulo 2^WIDTH.
//
//   Optional feature (macro CSA_ACCUM_FINAL_CPA_EN):
//     adds output out_sum = B_0 + B_1, registered. The result passes through
//     one extra output register, so out_valid rises two cycles after the last
//     beat is accepted instead of one.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   beat present on in_rows
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   in_rows    in   ROWS*WIDTH, row k at [k*WIDTH +: WIDTH]
//   in_last    in   final beat of the accumulation
//   out_valid  out  result pair valid
//   out_ready  in   consumer accepts the result
//   B_0, B_1   out  WIDTH carry-save result words
//   out_beats  out  CNT_W beats folded into the presented result
//   out_ovf    out  accumulation ended by MAX_BEATS rather than in_last
//   out_sum    out  WIDTH (only with CSA_ACCUM_FINAL_CPA_EN) B_0 + B_1

module csa_accum_tree #(
    parameter int unsigned WIDTH     = 86,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*WIDTH-1:0] in_rows,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      B_0,
    output logic [WIDTH-1:0]      B_1,
    output logic [CNT_W-1:0]      out_beats,
    output logic                  out_ovf
`ifdef CSA_ACCUM_FINAL_CPA_EN
    ,
    output logic [WIDTH-1:0]      out_sum
`endif
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Row count entering tree level lvl; each level turns every full group
    // of three rows into two and passes the remainder straight through.
    function automatic int unsigned rows_at(input int unsigned lvl);
        int unsigned n;
        n = ROWS + 2;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = n - n / 3;
        end
        return n;
    endfunction

    function automatic int unsigned num_levels();
        int unsigned n;
        int unsigned l;
        n = ROWS + 2;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = num_levels();

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] acc0_q, acc0_d;
    logic [WIDTH-1:0] acc1_q, acc1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_b0_q, res_b0_d;
    logic [WIDTH-1:0] res_b1_q, res_b1_d;
    logic [CNT_W-1:0] res_beats_q, res_beats_d;
    logic             res_ovf_q, res_ovf_d;

    logic             seed_zero;
    logic [WIDTH-1:0] seed0, seed1;
    logic [WIDTH-1:0] tree_s, tree_c;
    logic [CNT_W-1:0] cnt_base, cnt_inc;
    logic             term;
    logic             accept;
    logic             drain_ready;

    // A beat accepted in DONE starts a fresh accumulation, so it is seeded
    // with zero and counted from zero regardless of the stored accumulator.
    assign seed_zero = first_q || (state_q == DONE);
    assign seed0     = seed_zero ? '0 : acc0_q;
    assign seed1     = seed_zero ? '0 : acc1_q;
    assign cnt_base  = (state_q == DONE) ? '0 : cnt_q;
    assign cnt_inc   = cnt_base + CNT_W'(1);
    assign term      = in_last || (cnt_inc == CNT_W'(MAX_BEATS));

    // ---------------------------------------------------------------------
    // Compressor tree: level 0 holds the beat rows plus the seed pair; each
    // further level is one rank of 3:2 cells. Purely combinational.
    // ---------------------------------------------------------------------
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N_IN = rows_at(l);
        logic [WIDTH-1:0] r [N_IN];

        if (l == 0) begin : g_src
            for (genvar k = 0; k < ROWS; k++) begin : g_row
                assign r[k] = in_rows[k*WIDTH +: WIDTH];
            end
            assign r[ROWS]   = seed0;
            assign r[ROWS+1] = seed1;
        end else begin : g_red
            localparam int unsigned N_PREV = rows_at(l - 1);
            localparam int unsigned N_GRP  = N_PREV / 3;

            for (genvar g = 0; g < N_GRP; g++) begin : g_csa
                logic [WIDTH-1:0] a, b, c;
                assign a = g_lvl[l-1].r[3*g];
                assign b = g_lvl[l-1].r[3*g+1];
                assign c = g_lvl[l-1].r[3*g+2];
                assign r[2*g]   = a ^ b ^ c;
                // Majority shifted up one place; the top carry falls off.
                assign r[2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
            end

            for (genvar p = 0; p < N_PREV - 3*N_GRP; p++) begin : g_pass
                assign r[2*N_GRP+p] = g_lvl[l-1].r[3*N_GRP+p];
            end
        end
    end

    assign tree_s = g_lvl[LEVELS].r[0];
    assign tree_c = g_lvl[LEVELS].r[1];

    // ---------------------------------------------------------------------
    // Accumulation FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_b0_d    = res_b0_q;
        res_b1_d    = res_b1_q;
        res_beats_d = res_beats_q;
        res_ovf_d   = res_ovf_q;

        in_ready = (state_q == ACCUM) || drain_ready;
        accept   = in_valid && in_ready;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc0_d  = tree_s;
                    acc1_d  = tree_c;
                    first_d = 1'b0;
                    cnt_d   = cnt_inc;
                    if (term) begin
                        state_d     = DONE;
                        res_valid_d = 1'b1;
                        res_b0_d    = tree_s;
                        res_b1_d    = tree_c;
                        res_beats_d = cnt_inc;
                        res_ovf_d   = !in_last;
                    end
                end
            end
            DONE: begin
                if (drain_ready) begin
                    res_valid_d = 1'b0;
                    first_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = ACCUM;
                    if (accept) begin
                        acc0_d  = tree_s;
                        acc1_d  = tree_c;
                        first_d = 1'b0;
                        cnt_d   = cnt_inc;
                        if (term) begin
                            state_d     = DONE;
                            res_valid_d = 1'b1;
                            res_b0_d    = tree_s;
                            res_b1_d    = tree_c;
                            res_beats_d = cnt_inc;
                            res_ovf_d   = !in_last;
                        end
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            first_q     <= 1'b1;
            acc0_q      <= '0;
            acc1_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_b0_q    <= '0;
            res_b1_q    <= '0;
            res_beats_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_b0_q    <= res_b0_d;
            res_b1_q    <= res_b1_d;
            res_beats_q <= res_beats_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

`ifdef CSA_ACCUM_FINAL_CPA_EN
    // ---------------------------------------------------------------------
    // Output stage with final adder. The FSM result register acts as the
    // skid entry: it drains here whenever this stage is empty or being read.
    // ---------------------------------------------------------------------
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] ob0_q, ob0_d;
    logic [WIDTH-1:0] ob1_q, ob1_d;
    logic [WIDTH-1:0] osum_q, osum_d;
    logic [CNT_W-1:0] obeats_q, obeats_d;
    logic             oovf_q, oovf_d;

    assign drain_ready = !ov_q || out_ready;

    always_comb begin
        ov_d     = ov_q;
        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        osum_d   = osum_q;
        obeats_d = obeats_q;
        oovf_d   = oovf_q;
        if (out_ready) begin
            ov_d = 1'b0;
        end
        if (res_valid_q && drain_ready) begin
            ov_d     = 1'b1;
            ob0_d    = res_b0_q;
            ob1_d    = res_b1_q;
            osum_d   = res_b0_q + res_b1_q;
            obeats_d = res_beats_q;
            oovf_d   = res_ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q     <= 1'b0;
            ob0_q    <= '0;
            ob1_q    <= '0;
            osum_q   <= '0;
            obeats_q <= '0;
            oovf_q   <= 1'b0;
        end else begin
            ov_q     <= ov_d;
            ob0_q    <= ob0_d;
            ob1_q    <= ob1_d;
            osum_q   <= osum_d;
            obeats_q <= obeats_d;
            oovf_q   <= oovf_d;
        end
    end

    assign out_valid = ov_q;
    assign B_0       = ob0_q;
    assign B_1       = ob1_q;
    assign out_sum   = osum_q;
    assign out_beats = obeats_q;
    assign out_ovf   = oovf_q;
`else
    assign drain_ready = out_ready;
    assign out_valid   = res_valid_q;
    assign B_0         = res_b0_q;
    assign B_1         = res_b1_q;
    assign out_beats   = res_beats_q;
    assign out_ovf     = res_ovf_q;
`endif

endmodule

// File: tb/tb_csa_accum_tree.sv
module tb_csa_accum_tree;

    localparam int unsigned W = 86;
    localparam int unsigned R = 8;
`ifdef CSA_ACCUM_FINAL_CPA_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic clk;
    logic rst_n;

    // main instance: MAX_BEATS = 16
    logic           in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [R*W-1:0] in_rows;
    logic [W-1:0]   B_0, B_1, sum0;
    logic [4:0]     out_beats;

    // second instance: MAX_BEATS = 4
    logic           v4, irdy4, last4, ov4, rdy4, ovf4;
    logic [R*W-1:0] rows4;
    logic [W-1:0]   b0_4, b1_4, sum4;
    logic [2:0]     beats4;

`ifdef CSA_ACCUM_FINAL_CPA_EN
    logic [W-1:0]   out_sum, out_sum4;
`endif

    assign sum0 = B_0 + B_1;
    assign sum4 = b0_4 + b1_4;

    csa_accum_tree #(.WIDTH(W), .ROWS(R), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rows(in_rows), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .B_0(B_0), .B_1(B_1), .out_beats(out_beats), .out_ovf(out_ovf)
`ifdef CSA_ACCUM_FINAL_CPA_EN
        , .out_sum(out_sum)
`endif
    );

    csa_accum_tree #(.WIDTH(W), .ROWS(R), .MAX_BEATS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(irdy4), .in_rows(rows4), .in_last(last4),
        .out_valid(ov4), .out_ready(rdy4),
        .B_0(b0_4), .B_1(b1_4), .out_beats(beats4), .out_ovf(ovf4)
`ifdef CSA_ACCUM_FINAL_CPA_EN
        , .out_sum(out_sum4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [R*W-1:0] all_rows(input logic [W-1:0] v);
        logic [R*W-1:0] o;
        for (int unsigned k = 0; k < R; k++) o[k*W +: W] = v;
        return o;
    endfunction

    function automatic logic [R*W-1:0] row0_only(input logic [W-1:0] v);
        logic [R*W-1:0] o;
        o = '0;
        o[W-1:0] = v;
        return o;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [42:0]    a, b;
    logic [W-1:0]   aa, prod, exp_wrap, snap0, snap1;
    logic [R*W-1:0] vec;

    initial begin
        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        for (int unsigned i = 0; i < R*W; i++) begin
            in_rows[i] = 1'($urandom);
            rows4[i]   = 1'($urandom);
        end
        in_valid = 1'b1; in_last = 1'($urandom); out_ready = 1'($urandom);
        v4 = 1'b1; last4 = 1'b1; rdy4 = 1'($urandom);
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_b0", B_0, 0);
        chk("rst_b1", B_1, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_beats", out_beats, 0);
        chk("rst4_out_valid", ov4, 0);

        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_rows = '0;
        v4 = 1'b0; last4 = 1'b0; rdy4 = 1'b0; rows4 = '0;
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst4_in_ready", irdy4, 1);

        // ---------------- single beat, each row = 1 ----------------
        in_rows = all_rows(86'd1); in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (LAT - 1) step();
        chk("single_valid", out_valid, 1);
        chk("single_sum", sum0, 8);
        chk("single_beats", out_beats, 1);
        chk("single_ovf", out_ovf, 0);
`ifdef CSA_ACCUM_FINAL_CPA_EN
        chk("single_out_sum", out_sum, 8);
`endif
        out_ready = 1'b1;
        step();
        chk("single_consumed", out_valid, 0);
        out_ready = 1'b0;

        // ---------------- 43x43 multiply over 6 beats ----------------
        a = 43'({$urandom(), $urandom()});
        b = 43'({$urandom(), $urandom()});
        aa = W'(a);
        prod = W'(a) * W'(b);
        for (int unsigned j = 0; j < 6; j++) begin
            vec = '0;
            for (int unsigned k = 0; k < R; k++) begin
                if (j*R + k < 43) begin
                    if (b[j*R + k]) vec[k*W +: W] = aa << (j*R + k);
                end
            end
            in_rows = vec; in_last = (j == 5); in_valid = 1'b1;
            step();
            if (j < 5) chk("mul_pending", out_valid, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        repeat (LAT - 1) step();
        chk("mul_valid", out_valid, 1);
        chk("mul_product", sum0, prod);
        chk("mul_beats", out_beats, 6);
        chk("mul_ovf", out_ovf, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // ---------------- wrap: 8 rows of all ones ----------------
        exp_wrap = '0;
        exp_wrap = exp_wrap - 86'd8;
        in_rows = '1; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (LAT - 1) step();
        chk("wrap_valid", out_valid, 1);
        chk("wrap_sum", sum0, exp_wrap);

        // ---------------- backpressure, then overlapped beat ----------------
        snap0 = B_0; snap1 = B_1;
`ifndef CSA_ACCUM_FINAL_CPA_EN
        in_rows = all_rows(86'd1); in_last = 1'b1; in_valid = 1'b1;
`endif
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_b0_stable", B_0, snap0);
            chk("bp_b1_stable", B_1, snap1);
            chk("bp_sum", sum0, exp_wrap);
`ifndef CSA_ACCUM_FINAL_CPA_EN
            chk("bp_in_ready", in_ready, 0);
`endif
        end
        in_rows = all_rows(86'd1); in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (LAT - 1) step();
        chk("ovl_valid", out_valid, 1);
        chk("ovl_sum", sum0, 8);
        chk("ovl_beats", out_beats, 1);
        out_ready = 1'b1;
        step();
        chk("ovl_consumed", out_valid, 0);
        out_ready = 1'b0;

        // ---------------- forced termination, MAX_BEATS = 4 ----------------
        for (int unsigned j = 0; j < 4; j++) begin
            rows4 = row0_only(W'(j + 1)); last4 = 1'b0; v4 = 1'b1;
            step();
            if (j < 3) chk("ovf_pending", ov4, 0);
        end
        v4 = 1'b0;
        repeat (LAT - 1) step();
        chk("ovf_valid", ov4, 1);
        chk("ovf_flag", ovf4, 1);
        chk("ovf_beats", beats4, 4);
        chk("ovf_sum", sum4, 10);
        rdy4 = 1'b1;
        step();
        chk("ovf_consumed", ov4, 0);
        rdy4 = 1'b0;

        // in_last on the MAX_BEATS-th beat: not an overflow
        for (int unsigned j = 0; j < 4; j++) begin
            rows4 = row0_only(86'd1); last4 = (j == 3); v4 = 1'b1;
            step();
        end
        v4 = 1'b0; last4 = 1'b0;
        repeat (LAT - 1) step();
        chk("lastmax_valid", ov4, 1);
        chk("lastmax_ovf", ovf4, 0);
        chk("lastmax_beats", beats4, 4);
        chk("lastmax_sum", sum4, 4);

        // consume while starting a new accumulation, add a second beat, then reset
        rows4 = row0_only(86'd7); last4 = 1'b0; v4 = 1'b1; rdy4 = 1'b1;
        step();
        rdy4 = 1'b0;
        step();
        v4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", ov4, 0);
        chk("arst_b0", b0_4, 0);
        chk("arst_b1", b1_4, 0);
        chk("arst_beats", beats4, 0);
        chk("arst_in_ready", irdy4, 1);
        step();
        rst_n = 1'b1;
        step();
        rows4 = row0_only(86'd5); last4 = 1'b1; v4 = 1'b1;
        step();
        v4 = 1'b0; last4 = 1'b0;
        repeat (LAT - 1) step();
        chk("post_arst_valid", ov4, 1);
        chk("post_arst_sum", sum4, 5);
        chk("post_arst_beats", beats4, 1);
        chk("post_arst_ovf", ovf4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
